// File: rtl/cm0_dap_cdc_hs_rx.sv
// Receive side of the DAP four-phase CDC handshake.
// Captures REQDATA on request, hands it over by valid/ready, returns ACKOUT.
module cm0_dap_cdc_hs_rx #(
    parameter int DW      = 32,
    parameter int PRESENT = 1
) (
    input  logic          SYNCCLK,
    input  logic          SYNCRSTn,
    input  logic          REQSYNC,
    input  logic [DW-1:0] REQDATA,
    output logic          ACKOUT,
    output logic          RXVALID,
    output logic [DW-1:0] RXDATA,
    input  logic          RXREADY,
    input  logic          ERRCLR,
    output logic          PROTERR,
    output logic [7:0]    XFERCNT
);

    localparam logic EN = (PRESENT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACKH  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ack_nxt;
    logic          vld_nxt;
    logic          err_nxt;
    logic          err_set;
    logic [DW-1:0] data_nxt;
    logic [7:0]    cnt_nxt;

    always_comb begin
        state_nxt = state;
        ack_nxt   = ACKOUT;
        vld_nxt   = RXVALID;
        data_nxt  = RXDATA;
        cnt_nxt   = XFERCNT;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                vld_nxt = 1'b0;
                if (REQSYNC) begin
                    state_nxt = VALID;
                    vld_nxt   = 1'b1;
                    data_nxt  = REQDATA;
                end
            end
            VALID: begin
                // Early request drop is flagged but the word is still delivered
                err_set = ~REQSYNC;
                if (RXREADY) begin
                    state_nxt = ACKH;
                    vld_nxt   = 1'b0;
                    ack_nxt   = 1'b1;
                end
            end
            ACKH: begin
                if (!REQSYNC) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b0;
                    cnt_nxt   = XFERCNT + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
                vld_nxt   = 1'b0;
            end
        endcase
        err_nxt = err_set | (PROTERR & ~ERRCLR);
        if (!EN) begin
            state_nxt = IDLE;
            ack_nxt   = 1'b0;
            vld_nxt   = 1'b0;
            data_nxt  = '0;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
        end
    end

    always_ff @(posedge SYNCCLK) begin
        if (!SYNCRSTn) begin
            state   <= IDLE;
            ACKOUT  <= 1'b0;
            RXVALID <= 1'b0;
            RXDATA  <= '0;
            PROTERR <= 1'b0;
            XFERCNT <= '0;
        end else begin
            state   <= state_nxt;
            ACKOUT  <= ack_nxt;
            RXVALID <= vld_nxt;
            RXDATA  <= data_nxt;
            PROTERR <= err_nxt;
            XFERCNT <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cm0_dap_cdc_hs_rx.sv
// Bench for cm0_dap_cdc_hs_rx: directed plan plus random traffic
// against a transaction-level reference and a capture scoreboard.
module tb_cm0_dap_cdc_hs_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] data = '0;
    logic        ready = 1'b0;
    logic        errclr = 1'b0;

    logic        ack, vld, perr;
    logic [31:0] rxd;
    logic [7:0]  cnt;
    logic        z_ack, z_vld, z_perr;
    logic [31:0] z_rxd;
    logic [7:0]  z_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cm0_dap_cdc_hs_rx #(.DW(32), .PRESENT(1)) dut (
        .SYNCCLK(clk), .SYNCRSTn(rst_n), .REQSYNC(req), .REQDATA(data),
        .ACKOUT(ack), .RXVALID(vld), .RXDATA(rxd), .RXREADY(ready),
        .ERRCLR(errclr), .PROTERR(perr), .XFERCNT(cnt)
    );

    cm0_dap_cdc_hs_rx #(.DW(32), .PRESENT(0)) dut0 (
        .SYNCCLK(clk), .SYNCRSTn(rst_n), .REQSYNC(req), .REQDATA(data),
        .ACKOUT(z_ack), .RXVALID(z_vld), .RXDATA(z_rxd), .RXREADY(ready),
        .ERRCLR(errclr), .PROTERR(z_perr), .XFERCNT(z_cnt)
    );

    // Reference: a word is either absent, waiting for the consumer,
    // or acknowledged and waiting for the source to drop its request.
    bit          m_hold = 0;
    bit          m_acked = 0;
    bit [31:0]   m_data = '0;
    bit          m_err = 0;
    int          m_xfers = 0;
    bit [31:0]   q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit new_err;
        if (rst_n && vld && ready) begin
            chk("sb_depth", 64'(q.size()), 64'd1);
            if (q.size() > 0) chk("sb_data", 64'(rxd), 64'(q.pop_front()));
        end
        @(posedge clk);
        new_err = 0;
        if (!rst_n) begin
            m_hold = 0; m_acked = 0; m_data = '0;
            m_err = 0; m_xfers = 0; q.delete();
        end else begin
            if (m_acked) begin
                if (!req) begin
                    m_acked = 0;
                    m_xfers = (m_xfers + 1) % 256;
                end
            end else if (m_hold) begin
                new_err = !req;
                if (ready) begin
                    m_hold = 0;
                    m_acked = 1;
                end
            end else if (req) begin
                m_hold = 1;
                m_data = data;
                q.push_back(data);
            end
            if (new_err) m_err = 1;
            else if (errclr) m_err = 0;
        end
        #1;
        chk("ackout", 64'(ack), 64'(m_acked));
        chk("rxvalid", 64'(vld), 64'(m_hold));
        chk("rxdata", 64'(rxd), 64'(m_data));
        chk("proterr", 64'(perr), 64'(m_err));
        chk("xfercnt", 64'(cnt), 64'(m_xfers));
        chk("absent", {z_rxd, z_cnt, z_ack, z_vld, z_perr}, 64'd0);
    endtask

    initial begin
        // Reset
        rst_n = 0;
        step(); step();
        chk("rst_cnt", 64'(cnt), 64'd0);
        rst_n = 1;
        step();

        // Basic transfer
        data = 32'hA5A5_0001; req = 1; ready = 1;
        step();
        chk("basic_vld", 64'(vld), 64'd1);
        chk("basic_data", 64'(rxd), 64'hA5A5_0001);
        step();
        chk("basic_ack", 64'(ack), 64'd1);
        req = 0;
        step();
        chk("basic_ackdrop", 64'(ack), 64'd0);
        chk("basic_cnt", 64'(cnt), 64'd1);

        // Backpressure with changing source data
        step();
        ready = 0; req = 1;
        step();
        data = 32'h0000_FFFF;
        repeat (10) step();
        chk("bp_data", 64'(rxd), 64'hA5A5_0001);
        chk("bp_noack", 64'(ack), 64'd0);
        ready = 1;
        step();
        chk("bp_ack", 64'(ack), 64'd1);
        req = 0;
        step();

        // Protocol error, then clear, then clear coincident with new error
        ready = 0; req = 1;
        step(); step();
        req = 0;
        step();
        chk("err_set", 64'(perr), 64'd1);
        ready = 1;
        step();
        chk("err_ack", 64'(ack), 64'd1);
        step();
        chk("err_ackpulse", 64'(ack), 64'd0);
        chk("err_cnt", 64'(cnt), 64'd3);
        errclr = 1;
        step();
        chk("err_clr", 64'(perr), 64'd0);
        errclr = 0; ready = 0; req = 1;
        step();
        req = 0; errclr = 1;
        step();
        chk("err_setwins", 64'(perr), 64'd1);
        errclr = 0; ready = 1;
        step(); step();

        // Reset while acknowledging
        req = 1; ready = 1; data = 32'h1234_5678;
        step(); step();
        rst_n = 0;
        step();
        chk("mid_rst_ack", 64'(ack), 64'd0);
        chk("mid_rst_data", 64'(rxd), 64'd0);
        rst_n = 1;
        step();
        chk("post_rst_cap", 64'(vld), 64'd1);
        req = 0;
        step(); step();

        // Counter wrap
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < 256; i++) begin
            data = $urandom; req = 1; ready = 1;
            step(); step();
            req = 0;
            step();
        end
        chk("wrap", 64'(cnt), 64'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = ~req;
            data   = $urandom;
            ready  = 1'($urandom_range(0, 1));
            errclr = ($urandom_range(0, 15) == 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
